// File: rtl/interval_timer_pkg.sv
// Shared definitions for the interval timer: state encoding and default widths.
package interval_timer_pkg;

  // Default operand widths used by the interface, the top and the prescaler.
  localparam int DEFAULT_WIDTH          = 8;
  localparam int DEFAULT_PRESCALE_WIDTH = 4;

  // Controller state encoding: IDLE = 0, RUN = 1.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Number of clock edges from the start edge to the edge that raises tick.
  function automatic int interval_edges(input int period, input int prescale);
    return (period + 1) * (prescale + 1);
  endfunction

endpackage

// File: rtl/interval_timer_if.sv
// Control/status bundle between the command logic (master) and the timer (slave).
interface interval_timer_if
  import interval_timer_pkg::*;
#(
  parameter int WIDTH          = DEFAULT_WIDTH,
  parameter int PRESCALE_WIDTH = DEFAULT_PRESCALE_WIDTH
);

  logic                      start;
  logic                      stop;
  logic                      periodic;
  logic [WIDTH-1:0]          period;
  logic [PRESCALE_WIDTH-1:0] prescale;
  logic                      busy;
  logic                      tick;
  logic                      done;
  logic [WIDTH-1:0]          count;

  // Command side: requests and configuration out, status in.
  modport master (
    output start, stop, periodic, period, prescale,
    input  busy, tick, done, count
  );

  // Timer side: requests and configuration in, status out.
  modport slave (
    input  start, stop, periodic, period, prescale,
    output busy, tick, done, count
  );

endinterface

// File: rtl/interval_timer_tick_prescaler.sv
// Clock divider that produces one enable pulse every (divisor+1) cycles while running.
module tick_prescaler
  import interval_timer_pkg::*;
#(
  parameter int PRESCALE_WIDTH = DEFAULT_PRESCALE_WIDTH
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      clear,
  input  logic                      run,
  input  logic [PRESCALE_WIDTH-1:0] divisor,
  output logic                      enable
);

  logic [PRESCALE_WIDTH-1:0] cnt_reg;
  logic [PRESCALE_WIDTH-1:0] cnt_next;

  // The pulse fires on the edge where the count has reached the divisor.
  assign enable = run && (cnt_reg == divisor);

  // Next count: clear wins, then wrap on enable, otherwise advance while running.
  always_comb begin
    cnt_next = cnt_reg;
    if (clear) begin
      cnt_next = '0;
    end else if (run) begin
      if (enable) begin
        cnt_next = '0;
      end else begin
        cnt_next = cnt_reg + 1'b1;
      end
    end
  end

  // Prescaler count register.
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_next;
    end
  end

endmodule

// File: rtl/interval_timer.sv
// Programmable interval timer: prescaled up-counter with terminal compare,
// one-shot and periodic modes, single-cycle tick and done pulses.
module interval_timer
  import interval_timer_pkg::*;
#(
  parameter int WIDTH          = DEFAULT_WIDTH,
  parameter int PRESCALE_WIDTH = DEFAULT_PRESCALE_WIDTH
) (
  input  logic            clock,
  input  logic            reset,
  interval_timer_if.slave bus
);

  state_t                    state_reg,    state_next;
  logic [WIDTH-1:0]          count_reg,    count_next;
  logic [WIDTH-1:0]          period_reg,   period_next;
  logic [PRESCALE_WIDTH-1:0] prescale_reg, prescale_next;
  logic                      periodic_reg, periodic_next;
  logic                      tick_reg,     tick_next;
  logic                      done_reg,     done_next;

  logic presc_clear;
  logic presc_run;
  logic presc_enable;

  // Prescaler is held at zero whenever the timer is idle (which also covers
  // the start edge) and on an abort, so every run begins with a full divide.
  assign presc_run   = (state_reg == ST_RUN);
  assign presc_clear = (state_reg == ST_IDLE) || bus.stop;

  tick_prescaler #(
    .PRESCALE_WIDTH (PRESCALE_WIDTH)
  ) u_prescaler (
    .clock   (clock),
    .reset   (reset),
    .clear   (presc_clear),
    .run     (presc_run),
    .divisor (prescale_reg),
    .enable  (presc_enable)
  );

  // Next-state and datapath control: arm from IDLE, count on enable,
  // terminal compare ahead of the increment so count never overflows.
  always_comb begin
    state_next    = state_reg;
    count_next    = count_reg;
    period_next   = period_reg;
    prescale_next = prescale_reg;
    periodic_next = periodic_reg;
    tick_next     = 1'b0;
    done_next     = 1'b0;

    unique case (state_reg)
      ST_IDLE: begin
        // stop beats start when both arrive in the same idle cycle
        if (bus.start && !bus.stop) begin
          state_next    = ST_RUN;
          count_next    = '0;
          period_next   = bus.period;
          prescale_next = bus.prescale;
          periodic_next = bus.periodic;
        end
      end

      ST_RUN: begin
        if (bus.stop) begin
          // abort suppresses any tick/done that would have coincided
          state_next = ST_IDLE;
          count_next = '0;
        end else if (presc_enable) begin
          if (count_reg == period_reg) begin
            tick_next  = 1'b1;
            count_next = '0;
            if (!periodic_reg) begin
              state_next = ST_IDLE;
              done_next  = 1'b1;
            end
          end else begin
            count_next = count_reg + 1'b1;
          end
        end
      end

      default: begin
        state_next = ST_IDLE;
        count_next = '0;
      end
    endcase
  end

  // State, count, latched configuration and output pulse registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg    <= ST_IDLE;
      count_reg    <= '0;
      period_reg   <= '0;
      prescale_reg <= '0;
      periodic_reg <= 1'b0;
      tick_reg     <= 1'b0;
      done_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      count_reg    <= count_next;
      period_reg   <= period_next;
      prescale_reg <= prescale_next;
      periodic_reg <= periodic_next;
      tick_reg     <= tick_next;
      done_reg     <= done_next;
    end
  end

  assign bus.busy  = (state_reg == ST_RUN);
  assign bus.tick  = tick_reg;
  assign bus.done  = done_reg;
  assign bus.count = count_reg;

endmodule

// File: tb/tb_interval_timer.sv
// Self-checking bench for interval_timer: directed scenarios followed by
// randomized traffic, all compared against an elapsed-time arithmetic model.
module tb_interval_timer;

  localparam int W  = 8;
  localparam int PW = 4;

  logic clock = 1'b0;
  logic reset = 1'b1;

  interval_timer_if #(.WIDTH(W), .PRESCALE_WIDTH(PW)) bus ();

  interval_timer #(.WIDTH(W), .PRESCALE_WIDTH(PW)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int n_vec  = 0;
  int n_miss = 0;
  int cyc    = 0;

  // Reference model: a run is described only by the edges elapsed since the
  // start edge and the latched configuration.
  bit m_run = 1'b0;
  int m_e   = 0;
  int m_p   = 0;
  int m_d   = 0;
  bit m_per = 1'b0;

  task automatic check_val(input string tag, input logic [31:0] observed,
                           input logic [31:0] expected);
    n_vec++;
    if (observed !== expected) begin
      n_miss++;
      $display("FAIL %s @cycle %0d: observed %0d expected %0d", tag, cyc, observed, expected);
    end
  endtask

  // Apply one cycle of inputs, advance the model across the edge, compare outputs.
  task automatic step(input bit r, input bit s, input bit st, input bit per,
                      input int pd, input int pr);
    int len;
    int pos;
    bit e_tick, e_done, e_busy;
    int e_count;
    @(negedge clock);
    reset        = r;
    bus.start    = s;
    bus.stop     = st;
    bus.periodic = per;
    bus.period   = pd[W-1:0];
    bus.prescale = pr[PW-1:0];
    @(posedge clock);
    cyc++;
    e_tick = 1'b0; e_done = 1'b0; e_count = 0;
    if (r) begin
      m_run = 1'b0;
    end else if (!m_run) begin
      if (s && !st) begin
        m_run = 1'b1; m_e = 0;
        m_p = pd % (1 << W); m_d = pr % (1 << PW); m_per = per;
        $display("cycle %0d: arm periodic=%0d period=%0d prescale=%0d", cyc, m_per, m_p, m_d);
      end
    end else if (st) begin
      m_run = 1'b0;
    end else begin
      m_e++;
      len     = (m_p + 1) * (m_d + 1);
      pos     = m_e % len;
      e_tick  = (pos == 0);
      e_count = pos / (m_d + 1);
      if (e_tick && !m_per) begin
        e_done = 1'b1;
        m_run  = 1'b0;
      end
    end
    e_busy = m_run;
    #1;
    check_val("tick",  32'(bus.tick),  32'(e_tick));
    check_val("done",  32'(bus.done),  32'(e_done));
    check_val("busy",  32'(bus.busy),  32'(e_busy));
    check_val("count", 32'(bus.count), 32'(e_count));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    bus.start = 0; bus.stop = 0; bus.periodic = 0; bus.period = '0; bus.prescale = '0;

    // reset, then quiet idle
    step(1, 0, 0, 0, 0, 0);
    idle(10);

    // periodic, period 3, prescale 0: ticks at +4, +8, +12
    step(0, 1, 0, 1, 3, 0);
    idle(13);
    step(0, 0, 1, 0, 0, 0);
    idle(2);

    // one-shot, period 2, prescale 1: tick+done at +6, then silent
    step(0, 1, 0, 0, 2, 1);
    idle(10);

    // periodic period 1, stop on the terminal edge; then start+stop together
    step(0, 1, 0, 1, 1, 0);
    idle(1);
    step(0, 0, 1, 0, 0, 0);
    step(0, 1, 1, 1, 5, 0);
    idle(3);

    // start while busy is ignored; reset mid-run
    step(0, 1, 0, 1, 3, 0);
    step(0, 1, 0, 0, 7, 2);
    idle(10);
    step(1, 0, 0, 0, 0, 0);
    idle(3);

    // full-range period: count reaches 255, tick at +256, wraps cleanly
    step(0, 1, 0, 1, 255, 0);
    idle(520);
    step(0, 0, 1, 0, 0, 0);
    idle(2);

    // randomized traffic with live config changes while running
    for (int i = 0; i < 4000; i++) begin
      bit r, s, st, per;
      int pd, pr;
      r   = ($urandom_range(0, 299) == 0);
      s   = ($urandom_range(0, 7) == 0);
      st  = ($urandom_range(0, 59) == 0);
      per = 1'($urandom_range(0, 1));
      pd  = ($urandom_range(0, 15) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 7));
      pr  = int'($urandom_range(0, 15));
      step(r, s, st, per, pd, pr);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
